xy2_100_rx: RTL and testbench
=============================

Name: xy2_100_rx

Overview:
- Dedicated XY2-100 galvo-command receiver. Oversamples the external xy_clk/xy_sync/xy_x/xy_y lines on the internal oscillator clock.
- Deframes 20-bit frames and checks the control bits and parity for each channel.
- Delivers validated 16-bit X/Y position targets, with valid pulses, to the position PID stage.
- Also provides link-health status (xy_status pin) and error counters for the SPI register map.

Parameters:
SYNC_STAGES, 2, synchronizer flops on each XY2 input (min 2)
TIMEOUT_CYCLES, 82000, clk_in cycles without an accepted frame before link_lost (~1 ms)
CNT_W, 16, width of frame/error counters

Ports:
clk_in  in  1  system clock, 82 MHz internal oscillator
cnt_rstn  in  1  reset, asynchronous, active-low
xy_clk  in  1  XY2-100 clock (2 MHz), asynchronous
xy_sync  in  1  XY2-100 sync, asynchronous
xy_x  in  1  X channel serial data, asynchronous
xy_y  in  1  Y channel serial data, asynchronous
clr_err  in  1  synchronous pulse: clears err_sticky and frame_err_cnt
x_pos  out  16  last accepted X position
y_pos  out  16  last accepted Y position
x_valid  out  1  1-cycle pulse, x_pos updated
y_valid  out  1  1-cycle pulse, y_pos updated
link_lost  out  1  no accepted frame within TIMEOUT_CYCLES
err_sticky  out  1  any frame error since reset/clr_err
xy_status  out  1  link_lost | err_sticky
frame_cnt  out  CNT_W  accepted-frame counter, wraps
frame_err_cnt  out  CNT_W  rejected-frame counter, saturates at all-ones

Behaviour:
- Reset: cnt_rstn is asynchronous, active-low; clock is clk_in. Reset values:
  - x_pos = y_pos = 16'h8000
  - x_valid = y_valid = 0
  - link_lost = 1, err_sticky = 0, xy_status = 1
  - counters = 0, FSM = IDLE
  - synchronizers and edge registers = 0
- Reset asserted mid-frame discards the partial frame; no outputs pulse.
- Input path:
  - All four inputs pass through SYNC_STAGES flops, plus one history flop on xy_clk.
  - Sample event = synchronized xy_clk falling edge (history 1, current 0).
  - sync/x/y are read from their synchronized values in that same cycle.
- Frame format (per channel, MSB first):
  - bits 19..17 are control, must equal 3'b001
  - bits 16..1 are data[15:0]
  - bit 0 is parity
  - xy_sync is sampled 1 for bits 19..1 and 0 for the parity bit
  - parity is even: XOR of all 20 bits == 0
- FSM:
  - IDLE: sample with sync=1 → load bit into the X/Y shift registers, bitcnt=1, go to SHIFT. Sample with sync=0 → stay in IDLE.
  - SHIFT, sample with sync=1: shift bit in; bitcnt increments and saturates at 20.
  - SHIFT, sample with sync=0: shift the parity bit in, go to CHECK.
  - CHECK (exactly 1 cycle): evaluate, then return to IDLE.
  - A back-to-back frame is safe: the next sample edge cannot arrive within 1 cycle.
- CHECK evaluation:
  - len_ok = (bitcnt == 19).
  - Channel c is good when len_ok, control == 001, and parity even.
  - For each good channel, on the cycle after CHECK: c_pos ← data and c_valid = 1 for one cycle, independently per channel.
  - If both channels are good: frame_cnt += 1 (wrapping), and the timeout counter is cleared.
  - Otherwise: frame_err_cnt += 1 (saturating) and err_sticky ← 1.
  - A length error rejects both channels.
- Latency: pin edge → sample detect takes SYNC_STAGES+1 cycles; pos/valid update 2 cycles after the parity-bit sample event.
- Timeout:
  - Counter increments every cycle and saturates at TIMEOUT_CYCLES.
  - link_lost = (counter == TIMEOUT_CYCLES).
  - Counter is cleared only by an accepted frame; link_lost deasserts in the cycle after that clear.
- clr_err coinciding with a frame error: the error wins. err_sticky=1 and frame_err_cnt=1.
- xy_status is a registered OR, 1 cycle behind its sources.

Test Plan:
- Good frame, X=0x1234 (parity 0), Y=0xFFFF (parity 1), 2 MHz → x_pos=0x1234, y_pos=0xFFFF; x_valid and y_valid pulse once in the same cycle; frame_cnt=1; link_lost 1→0.
- Y parity flipped, X good → x_pos updates and x_valid pulses; y_pos stays 0x8000 with no y_valid; frame_err_cnt=1; err_sticky=1; xy_status=1.
- X control = 3'b000 → X rejected, frame_err_cnt increments; then assert clr_err → err_sticky=0, frame_err_cnt=0.
- Sync high for 22 bits, then one low (too long), and separately a 10-bit frame (too short) → no valid pulses; frame_err_cnt=2.
- 100 back-to-back good frames with incrementing X → 100 x_valid pulses, each x_pos matches, frame_cnt=100; then xy_clk stopped for TIMEOUT_CYCLES → link_lost=1 exactly at count TIMEOUT_CYCLES.
- cnt_rstn asserted at bit 10 of a frame, released, then a full good frame → outputs return to reset values; only the post-reset frame is accepted; frame_cnt=1.

Source files
------------

// File: rtl/xy2_100_rx.sv
// XY2-100 galvo command receiver: oversampling, deframing, validation,
// link-health monitoring and frame/error counters.
module xy2_100_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 82000,
    parameter int CNT_W          = 16
) (
    input  logic             clk_in,
    input  logic             cnt_rstn,
    input  logic             xy_clk,
    input  logic             xy_sync,
    input  logic             xy_x,
    input  logic             xy_y,
    input  logic             clr_err,
    output logic [15:0]      x_pos,
    output logic [15:0]      y_pos,
    output logic             x_valid,
    output logic             y_valid,
    output logic             link_lost,
    output logic             err_sticky,
    output logic             xy_status,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] frame_err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] clk_sy, sync_sy, x_sy, y_sy;
    logic                   clk_hist;
    logic                   sample;
    logic                   s_sync, s_x, s_y;

    logic [19:0] x_sr, y_sr;
    logic [4:0]  bitcnt;
    logic [TW-1:0] tcnt;

    logic len_ok, x_good, y_good, is_check, frame_ok, frame_bad;

    // Synchronize all four asynchronous inputs; keep one history flop on xy_clk
    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn) begin
            clk_sy   <= '0;
            sync_sy  <= '0;
            x_sy     <= '0;
            y_sy     <= '0;
            clk_hist <= 1'b0;
        end else begin
            clk_sy   <= {clk_sy[SYNC_STAGES-2:0], xy_clk};
            sync_sy  <= {sync_sy[SYNC_STAGES-2:0], xy_sync};
            x_sy     <= {x_sy[SYNC_STAGES-2:0], xy_x};
            y_sy     <= {y_sy[SYNC_STAGES-2:0], xy_y};
            clk_hist <= clk_sy[SYNC_STAGES-1];
        end
    end

    assign s_sync = sync_sy[SYNC_STAGES-1];
    assign s_x    = x_sy[SYNC_STAGES-1];
    assign s_y    = y_sy[SYNC_STAGES-1];
    assign sample = clk_hist & ~clk_sy[SYNC_STAGES-1];

    // FSM state register
    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn) state <= IDLE;
        else           state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (sample && s_sync) state_nx = SHIFT;
            SHIFT: if (sample && !s_sync) state_nx = CHECK;
            CHECK: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shift registers and bit counter; parity bit is shifted but not counted
    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn) begin
            x_sr   <= '0;
            y_sr   <= '0;
            bitcnt <= '0;
        end else if (sample) begin
            if (state == IDLE) begin
                if (s_sync) begin
                    x_sr   <= {19'b0, s_x};
                    y_sr   <= {19'b0, s_y};
                    bitcnt <= 5'd1;
                end
            end else if (state == SHIFT) begin
                x_sr <= {x_sr[18:0], s_x};
                y_sr <= {y_sr[18:0], s_y};
                if (s_sync && bitcnt != 5'd20) bitcnt <= bitcnt + 5'd1;
            end
        end
    end

    assign is_check  = (state == CHECK);
    assign len_ok    = (bitcnt == 5'd19);
    assign x_good    = len_ok && (x_sr[19:17] == 3'b001) && !(^x_sr);
    assign y_good    = len_ok && (y_sr[19:17] == 3'b001) && !(^y_sr);
    assign frame_ok  = x_good && y_good;
    assign frame_bad = is_check && !frame_ok;

    // Per-channel position update and valid pulse, one cycle after CHECK
    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn) begin
            x_pos   <= 16'h8000;
            y_pos   <= 16'h8000;
            x_valid <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            x_valid <= is_check && x_good;
            y_valid <= is_check && y_good;
            if (is_check && x_good) x_pos <= x_sr[16:1];
            if (is_check && y_good) y_pos <= y_sr[16:1];
        end
    end

    // Accepted-frame counter (wraps) and error tracking; error beats clr_err
    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn) begin
            frame_cnt     <= '0;
            frame_err_cnt <= '0;
            err_sticky    <= 1'b0;
        end else begin
            if (is_check && frame_ok) frame_cnt <= frame_cnt + 1'b1;
            if (frame_bad) begin
                err_sticky <= 1'b1;
                if (clr_err)
                    frame_err_cnt <= CNT_W'(1);
                else if (frame_err_cnt != '1)
                    frame_err_cnt <= frame_err_cnt + 1'b1;
            end else if (clr_err) begin
                err_sticky    <= 1'b0;
                frame_err_cnt <= '0;
            end
        end
    end

    // Link timeout: starts saturated so the link reads lost until a frame lands
    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn)                tcnt <= T_MAX;
        else if (is_check && frame_ok) tcnt <= '0;
        else if (tcnt != T_MAX)       tcnt <= tcnt + 1'b1;
    end

    assign link_lost = (tcnt == T_MAX);

    // Registered status pin
    always_ff @(posedge clk_in or negedge cnt_rstn) begin
        if (!cnt_rstn) xy_status <= 1'b1;
        else           xy_status <= link_lost | err_sticky;
    end

endmodule

// File: tb/tb_xy2_100_rx.sv
// Bench for xy2_100_rx: directed table, randomized frames against a
// frame-level model, bulk stream, timeout and mid-frame reset.
module tb_xy2_100_rx;

    localparam int TMO = 1000;

    logic        clk_in = 1'b0;
    logic        cnt_rstn = 1'b0;
    logic        xy_clk = 1'b0, xy_sync = 1'b0, xy_x = 1'b0, xy_y = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] x_pos, y_pos;
    logic        x_valid, y_valid, link_lost, err_sticky, xy_status;
    logic [15:0] frame_cnt, frame_err_cnt;

    xy2_100_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk_in(clk_in), .cnt_rstn(cnt_rstn),
        .xy_clk(xy_clk), .xy_sync(xy_sync), .xy_x(xy_x), .xy_y(xy_y),
        .clr_err(clr_err),
        .x_pos(x_pos), .y_pos(y_pos), .x_valid(x_valid), .y_valid(y_valid),
        .link_lost(link_lost), .err_sticky(err_sticky), .xy_status(xy_status),
        .frame_cnt(frame_cnt), .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk_in = ~clk_in;

    int vec = 0, miss = 0;
    int cyc = 0;
    int xv_cnt = 0, yv_cnt = 0, bv_cnt = 0, last_acc = 0;

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (x_valid) xv_cnt++;
        if (y_valid) yv_cnt++;
        if (x_valid && y_valid) begin
            bv_cnt++;
            last_acc = cyc;
        end
    end

    typedef struct {
        logic [2:0]  xc;
        logic [15:0] xd;
        bit          xpf;
        logic [2:0]  yc;
        logic [15:0] yd;
        bit          ypf;
        int          n;
        int          exv;
        int          eyv;
        logic [15:0] ex;
        logic [15:0] ey;
        int          efc;
        int          eec;
        int          esticky;
        int          estat;
        bit          clr;
    } vec_t;

    vec_t tbl[5];

    // model state
    logic [15:0] m_x, m_y;
    int m_fc, m_ec, m_sticky, m_xv, m_yv;

    function automatic logic [19:0] mk(logic [2:0] c, logic [15:0] d, bit pf);
        logic [18:0] b;
        b = {c, d};
        return {b, (^b) ^ pf};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [31:0] xb, input logic [31:0] yb,
                             input int n, input int nsend, input int h);
        for (int i = n - 1; i >= n - nsend; i--) begin
            xy_clk  = 1'b1;
            xy_sync = (i != 0);
            xy_x    = xb[i];
            xy_y    = yb[i];
            repeat (h) @(negedge clk_in);
            xy_clk = 1'b0;
            repeat (h) @(negedge clk_in);
        end
    endtask

    task automatic do_frame(input logic [19:0] xw, input logic [19:0] yw,
                            input int n, input int h);
        send_bits({12'b0, xw}, {12'b0, yw}, n, n, h);
        repeat (8) @(negedge clk_in);
    endtask

    // Frame-level reference: a channel is accepted only for a 20-bit frame
    // whose top three bits are 001 and whose 20 bits have even parity.
    task automatic model_frame(input logic [19:0] xw, input logic [19:0] yw,
                               input int n);
        bit gx, gy;
        gx = (n == 20) && (xw[19:17] == 3'b001) && ((^xw) == 1'b0);
        gy = (n == 20) && (yw[19:17] == 3'b001) && ((^yw) == 1'b0);
        m_xv = gx;
        m_yv = gy;
        if (gx) m_x = xw[16:1];
        if (gy) m_y = yw[16:1];
        if (gx && gy) begin
            m_fc = (m_fc + 1) % 65536;
        end else begin
            m_sticky = 1;
            if (m_ec < 65535) m_ec++;
        end
    endtask

    initial begin
        int xv0, yv0, bv0, t0, n;
        logic [19:0] xw, yw;
        logic [2:0] c;

        tbl[0] = '{3'b001, 16'h1234, 1'b0, 3'b001, 16'hFFFF, 1'b0, 20,
                   1, 1, 16'h1234, 16'hFFFF, 1, 0, 0, 0, 1'b0};
        tbl[1] = '{3'b001, 16'h00AA, 1'b0, 3'b001, 16'hFFFF, 1'b1, 20,
                   1, 0, 16'h00AA, 16'hFFFF, 1, 1, 1, 1, 1'b0};
        tbl[2] = '{3'b000, 16'h3333, 1'b0, 3'b001, 16'h5555, 1'b0, 20,
                   0, 1, 16'h00AA, 16'h5555, 1, 2, 1, 1, 1'b1};
        tbl[3] = '{3'b001, 16'h1111, 1'b0, 3'b001, 16'h2222, 1'b0, 23,
                   0, 0, 16'h00AA, 16'h5555, 1, 1, 1, 1, 1'b0};
        tbl[4] = '{3'b001, 16'h1111, 1'b0, 3'b001, 16'h2222, 1'b0, 10,
                   0, 0, 16'h00AA, 16'h5555, 1, 2, 1, 1, 1'b0};

        repeat (3) @(negedge clk_in);
        chk("rst_x_pos", x_pos, 16'h8000);
        chk("rst_y_pos", y_pos, 16'h8000);
        chk("rst_valid", {x_valid, y_valid}, 0);
        chk("rst_link_lost", link_lost, 1);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_xy_status", xy_status, 1);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_frame_err_cnt", frame_err_cnt, 0);
        cnt_rstn = 1'b1;
        repeat (3) @(negedge clk_in);

        // directed table at roughly 2 MHz
        for (int i = 0; i < 5; i++) begin
            xv0 = xv_cnt; yv0 = yv_cnt; bv0 = bv_cnt;
            xw = mk(tbl[i].xc, tbl[i].xd, tbl[i].xpf);
            yw = mk(tbl[i].yc, tbl[i].yd, tbl[i].ypf);
            send_bits({12'b0, xw}, {12'b0, yw}, tbl[i].n, tbl[i].n, 20);
            repeat (8) @(negedge clk_in);
            chk($sformatf("t%0d_x_valid", i), xv_cnt - xv0, tbl[i].exv);
            chk($sformatf("t%0d_y_valid", i), yv_cnt - yv0, tbl[i].eyv);
            chk($sformatf("t%0d_same_cycle", i), bv_cnt - bv0,
                tbl[i].exv * tbl[i].eyv);
            chk($sformatf("t%0d_x_pos", i), x_pos, tbl[i].ex);
            chk($sformatf("t%0d_y_pos", i), y_pos, tbl[i].ey);
            chk($sformatf("t%0d_frame_cnt", i), frame_cnt, tbl[i].efc);
            chk($sformatf("t%0d_err_sticky", i), err_sticky, tbl[i].esticky);
            chk($sformatf("t%0d_xy_status", i), xy_status, tbl[i].estat);
            if (i == 0) chk("t0_link_lost", link_lost, 0);
            if (tbl[i].clr) begin
                chk($sformatf("t%0d_err_cnt_pre", i), frame_err_cnt, 2);
                clr_err = 1'b1;
                @(negedge clk_in);
                clr_err = 1'b0;
                repeat (2) @(negedge clk_in);
                chk("clr_err_sticky", err_sticky, 0);
                chk("clr_err_cnt", frame_err_cnt, 0);
            end else begin
                chk($sformatf("t%0d_err_cnt", i), frame_err_cnt, tbl[i].eec);
            end
        end

        // randomized frames vs model
        m_x = 16'h00AA; m_y = 16'h5555;
        m_fc = 1; m_ec = 2; m_sticky = 1;
        for (int k = 0; k < 40; k++) begin
            xw = mk(3'b001, 16'($urandom), 1'b0);
            yw = mk(3'b001, 16'($urandom), 1'b0);
            n = 20;
            case ($urandom_range(0, 5))
                2: xw[0] = ~xw[0];
                3: begin
                    c = 3'($urandom);
                    yw = mk(c, yw[16:1], 1'b0);
                end
                4: n = $urandom_range(5, 25);
                5: yw[7] = ~yw[7];
                default: ;
            endcase
            xv0 = xv_cnt; yv0 = yv_cnt;
            model_frame(xw, yw, n);
            do_frame(xw, yw, n, 4);
            chk($sformatf("r%0d_x_valid", k), xv_cnt - xv0, m_xv);
            chk($sformatf("r%0d_y_valid", k), yv_cnt - yv0, m_yv);
            chk($sformatf("r%0d_x_pos", k), x_pos, m_x);
            chk($sformatf("r%0d_y_pos", k), y_pos, m_y);
            chk($sformatf("r%0d_frame_cnt", k), frame_cnt, m_fc);
            chk($sformatf("r%0d_err_cnt", k), frame_err_cnt, m_ec);
            chk($sformatf("r%0d_err_sticky", k), err_sticky, m_sticky);
        end

        // 100 back-to-back good frames with incrementing X
        xv0 = xv_cnt;
        for (int k = 0; k < 100; k++) begin
            xw = mk(3'b001, 16'h0100 + 16'(k), 1'b0);
            yw = mk(3'b001, 16'h4242, 1'b0);
            model_frame(xw, yw, 20);
            send_bits({12'b0, xw}, {12'b0, yw}, 20, 20, 4);
            repeat (6) @(negedge clk_in);
            chk($sformatf("b%0d_x_pos", k), x_pos, m_x);
        end
        chk("bulk_x_valid", xv_cnt - xv0, 100);
        chk("bulk_frame_cnt", frame_cnt, m_fc);
        chk("bulk_link_lost", link_lost, 0);

        // link timeout after xy_clk stops
        t0 = 0;
        while (!link_lost && t0 < 3 * TMO) begin
            @(negedge clk_in);
            t0++;
        end
        chk("timeout_reached", link_lost, 1);
        chk("timeout_cycles", cyc - last_acc, TMO);

        // reset in the middle of a frame
        xv0 = xv_cnt; yv0 = yv_cnt;
        xw = mk(3'b001, 16'hBEEF, 1'b0);
        yw = mk(3'b001, 16'hCAFE, 1'b0);
        send_bits({12'b0, xw}, {12'b0, yw}, 20, 10, 4);
        cnt_rstn = 1'b0;
        xy_clk = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("mrst_x_pos", x_pos, 16'h8000);
        chk("mrst_frame_cnt", frame_cnt, 0);
        chk("mrst_link_lost", link_lost, 1);
        chk("mrst_err_cnt", frame_err_cnt, 0);
        cnt_rstn = 1'b1;
        repeat (20) @(negedge clk_in);
        chk("mrst_no_pulse", (xv_cnt - xv0) + (yv_cnt - yv0), 0);
        xw = mk(3'b001, 16'h0F0F, 1'b0);
        yw = mk(3'b001, 16'hF0F0, 1'b0);
        do_frame(xw, yw, 20, 4);
        chk("post_x_pos", x_pos, 16'h0F0F);
        chk("post_y_pos", y_pos, 16'hF0F0);
        chk("post_frame_cnt", frame_cnt, 1);
        chk("post_err_cnt", frame_err_cnt, 0);
        chk("post_link_lost", link_lost, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
